matrix_stream_out: RTL and testbench
====================================

Name: matrix_stream_out

Overview:
- Reverse-direction companion to the matrix memory.
- Snapshots a flattened ROWSxCOLS matrix bus (memory read-out or multiplier result) on a start pulse.
- Streams the snapshot one element per transfer over a valid/ready interface, carrying a linear address and a last flag.
- Feeds host readback, UART/DMA drains, or the write port of another matrix memory.

Parameters:
- ROWS, 10, matrix row count
- COLS, 10, matrix column count
- DATA_W, 8, element width in bits
- ADDR_W, 7, linear index width; must satisfy 2^ADDR_W >= ROWS*COLS

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to snapshot mat_data and begin streaming
- mat_data  input  ROWS*COLS*DATA_W  flattened matrix; element k at [k*DATA_W +: DATA_W], element 0 in the LSBs
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the final element is accepted
- out_valid  output  1  out_data/out_addr/out_last are valid
- out_ready  input  1  sink accepts the element this cycle
- out_data  output  DATA_W  current element
- out_addr  output  ADDR_W  linear index r*COLS+c of the current element
- out_last  output  1  high with the final element of the frame

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, out_valid, out_last = 0; out_data, out_addr = 0; row/col counters = 0; snapshot register = 0.
- States: IDLE, STREAM, FINISH.
- IDLE:
  - start=1 captures mat_data into the internal snapshot register on that edge.
  - Clears row=0, col=0 and moves to STREAM.
  - busy=1 and out_valid=1 from the next cycle, so first data appears 1 cycle after start.
- STREAM:
  - out_data = snapshot element at index row*COLS+col; out_addr = that index.
  - out_last = 1 only at row=ROWS-1, col=COLS-1.
  - A transfer occurs when out_valid && out_ready.
  - Without a transfer, out_data/out_addr/out_last hold stable and out_valid stays 1; out_valid never drops mid-frame.
  - On a transfer, advance row-major: col++, and when col=COLS-1, col=0 and row++. This gives at most one element per cycle; full throughput with out_ready held high is ROWS*COLS cycles.
  - A transfer with out_last=1 moves to FINISH; out_valid and out_last fall on that same edge.
- FINISH (one cycle): done=1, busy stays 1; next cycle returns to IDLE with busy=0 and done=0.
- start is ignored outside IDLE; the snapshot is never overwritten mid-frame.
- mat_data changes after capture do not affect the stream.
- start held high for several cycles in IDLE: only the first cycle is accepted. A new frame may start on the cycle after FINISH, in IDLE.
- Address arithmetic: index = row*COLS+col computed at ADDR_W bits; counters never exceed ROWS-1 and COLS-1, so there is no wrap.
- rst_n asserted mid-frame: immediate return to reset values; no done pulse; the partial frame is abandoned.

Optional Feature:
- Macro MATRIX_STREAM_TRANSPOSE_EN.
- Defined: traversal is column-major. row increments first; on row=ROWS-1, row=0 and col++. out_addr still reports the source index r*COLS+c. out_last is at row=ROWS-1, col=COLS-1. The sink therefore receives the transpose.
- Undefined: row-major order only, with no column-major logic synthesised.

Test Plan:
- Element k = k+1 (k=0..99), start pulse, out_ready=1 constant -> 100 transfers on consecutive cycles: out_data 1..100, out_addr 0..99, out_last only on addr 99, done one cycle after the last transfer, busy high for 101 cycles.
- Same data, out_ready toggling 1,0,0,1,... -> identical data/addr sequence; during ready=0, out_valid stays 1 and outputs are stable; no element is skipped or duplicated.
- Change mat_data to all 0xFF one cycle after start -> stream still emits 1..100.
- start pulsed again at transfer 50 -> ignored; frame completes normally with a single done.
- rst_n low at transfer 30 -> out_valid, busy, out_addr = 0 immediately; no done; a new start then streams from addr 0.
- With MATRIX_STREAM_TRANSPOSE_EN and element k = k -> out_addr sequence 0,10,20,...,90,1,11,...,99; out_data equals out_addr; out_last on addr 99.

Source files
------------

// File: rtl/matrix_stream_out.sv
// matrix_stream_out: snapshots a flattened ROWS x COLS matrix bus on a start
// pulse and drains it one element per valid/ready transfer, tagging each
// element with its linear source index r*COLS+c and a last-of-frame flag.
// Optional macro MATRIX_STREAM_TRANSPOSE_EN: walk the snapshot column-major
// so the sink receives the transpose (out_addr still reports the source index).
module matrix_stream_out #(
  parameter int ROWS   = 10,
  parameter int COLS   = 10,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ROWS*COLS*DATA_W-1:0] mat_data,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [ADDR_W-1:0]           out_addr,
  output logic                        out_last
);

  localparam int N     = ROWS * COLS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FINISH} state_t;

  state_t                       r_state;
  logic [N-1:0][DATA_W-1:0]     r_snap;
  logic [N-1:0][DATA_W-1:0]     w_mat;
  logic [ADDR_W-1:0]            r_row;
  logic [ADDR_W-1:0]            r_col;
  logic [ADDR_W-1:0]            w_nrow;
  logic [ADDR_W-1:0]            w_ncol;
  logic [ADDR_W-1:0]            w_nidx;
  logic                         w_nlast;
  logic                         w_xfer;

  assign w_mat  = mat_data;
  assign w_xfer = out_valid && out_ready;

  // Position of the element that follows the current one in traversal order
  always_comb begin
    w_nrow = r_row;
    w_ncol = r_col;
`ifdef MATRIX_STREAM_TRANSPOSE_EN
    if (r_row == ADDR_W'(ROWS - 1)) begin
      w_nrow = '0;
      w_ncol = r_col + ADDR_W'(1);
    end else begin
      w_nrow = r_row + ADDR_W'(1);
    end
`else
    if (r_col == ADDR_W'(COLS - 1)) begin
      w_ncol = '0;
      w_nrow = r_row + ADDR_W'(1);
    end else begin
      w_ncol = r_col + ADDR_W'(1);
    end
`endif
  end

  // Counters stay inside the matrix, so the source index never wraps
  assign w_nidx  = w_nrow * ADDR_W'(COLS) + w_ncol;
  assign w_nlast = (w_nrow == ADDR_W'(ROWS - 1)) && (w_ncol == ADDR_W'(COLS - 1));

  // Frame FSM; all stream outputs are registered and only move on a transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_snap    <= '0;
      r_row     <= '0;
      r_col     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Element 0 comes straight from the bus being captured this edge
            r_snap    <= w_mat;
            r_row     <= '0;
            r_col     <= '0;
            out_data  <= w_mat[0];
            out_addr  <= '0;
            out_last  <= (N == 1);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            r_state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_FINISH;
            end else begin
              r_row    <= w_nrow;
              r_col    <= w_ncol;
              out_data <= r_snap[w_nidx[IDX_W-1:0]];
              out_addr <= w_nidx;
              out_last <= w_nlast;
            end
          end
        end
        S_FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_stream_out.sv
// Bench for matrix_stream_out: a queue-based frame model checked every cycle,
// plus literal per-frame expectations on the captured transfer log.
module tb_matrix_stream_out;
  localparam int ROWS = 10, COLS = 10, DW = 8, AW = 7;
  localparam int N = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n, start, out_ready;
  logic [N*DW-1:0] mat_data;
  logic busy, done, out_valid, out_last;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_addr;

  matrix_stream_out #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_data(mat_data),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last));

  always #5 clk = ~clk;

  int mat_v [N];
  always_comb begin
    mat_data = '0;
    for (int k = 0; k < N; k++) mat_data[k*DW +: DW] = 8'(mat_v[k]);
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;
  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 streaming, 2 done-cycle; q holds remaining indices
  int m_phase = 0;
  bit m_rstval = 1;
  int m_snap [N];
  int q [$];
  // Transfer log for literal checks
  int got_data [N];
  int got_addr [N];
  int n_got = 0, n_done = 0, n_busy = 0;

  // Outputs at negedge reflect the last posedge; inputs seen here are what the
  // DUT samples on the next posedge, so the model advances after comparing.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_rstval = 1; q.delete();
    end
    chk("out_valid", int'(out_valid), int'(m_phase == 1));
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("done", int'(done), int'(m_phase == 2));
    if (m_phase == 1) begin
      chk("out_data", int'(out_data), m_snap[q[0]] & 8'hFF);
      chk("out_addr", int'(out_addr), q[0]);
      chk("out_last", int'(out_last), int'(q.size() == 1));
    end else if (m_rstval) begin
      chk("rst_data", int'(out_data), 0);
      chk("rst_addr", int'(out_addr), 0);
      chk("rst_last", int'(out_last), 0);
    end
    if (out_valid && out_ready && n_got < N) begin
      got_data[n_got] = int'(out_data);
      got_addr[n_got] = int'(out_addr);
      n_got++;
    end
    if (done) n_done++;
    if (busy) n_busy++;
    if (rst_n) begin
      case (m_phase)
        0: if (start) begin
          m_snap = mat_v;
          q.delete();
`ifdef MATRIX_STREAM_TRANSPOSE_EN
          for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) q.push_back(r * COLS + c);
`else
          for (int k = 0; k < N; k++) q.push_back(k);
`endif
          m_phase = 1; m_rstval = 0;
        end
        1: if (out_ready) begin
          void'(q.pop_front());
          if (q.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ready_mode 0: always ready; 1: ready on every third cycle.
  // chg: overwrite the bus with 0xFF the cycle after start. hold: start held 3 cycles.
  // restart_at / reset_at: transfer count at which to pulse start / assert reset (-1 off).
  task automatic run_frame(input int ready_mode, input bit chg, input bit hold,
                           input int restart_at, input int reset_at);
    int cyc;
    bit restarted;
    n_got = 0; n_done = 0; n_busy = 0;
    restarted = 0;
    start = 1'b1;
    out_ready = 1'b1;
    cyc = 0;
    while (cyc < 2000) begin
      tick();
      cyc++;
      if (!(hold && cyc < 3)) start = 1'b0;
      if (chg && cyc == 1) for (int k = 0; k < N; k++) mat_v[k] = 255;
      out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (restart_at >= 0 && !restarted && n_got == restart_at) begin
        start = 1'b1; restarted = 1;
      end
      if (reset_at >= 0 && n_got == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", int'(out_valid), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_addr", int'(out_addr), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_no_done", n_done, 0);
        return;
      end
      if (n_done > 0 && !busy) break;
    end
    chk("frame_timeout", int'(cyc < 2000), 1);
    tick(); tick();
  endtask

  // Literal expectations for a complete frame with element k = k+1 at capture
  task automatic check_log(input string tag, input bit chk_busy);
    int ea;
    chk({tag, "_count"}, n_got, N);
    chk({tag, "_done_pulses"}, n_done, 1);
    if (chk_busy) chk({tag, "_busy_cycles"}, n_busy, N + 1);
    chk({tag, "_first_data"}, got_data[0], 1);
    chk({tag, "_last_addr"}, got_addr[N-1], 99);
    for (int i = 0; i < N; i++) begin
`ifdef MATRIX_STREAM_TRANSPOSE_EN
      ea = (i % ROWS) * COLS + (i / ROWS);
`else
      ea = i;
`endif
      if (got_addr[i] != ea || got_data[i] != ea + 1) begin
        chk({tag, "_seq_addr"}, got_addr[i], ea);
        chk({tag, "_seq_data"}, got_data[i], ea + 1);
      end
    end
    chk({tag, "_seq_ok"}, 1, 1 - int'(n_got != N));
  endtask

  task automatic load_ramp();
    for (int k = 0; k < N; k++) mat_v[k] = k + 1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
    load_ramp();
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    run_frame(0, 0, 0, -1, -1);
    check_log("full_rate", 1);

    run_frame(1, 0, 0, -1, -1);
    check_log("ready_toggle", 0);

    run_frame(0, 1, 0, -1, -1);
    check_log("bus_change", 1);
    load_ramp();

    run_frame(0, 0, 1, 50, -1);
    check_log("restart_ignored", 1);

    run_frame(0, 0, 0, -1, 30);
    chk("abandoned_count", n_got, 30);

    run_frame(0, 0, 0, -1, -1);
    check_log("after_reset", 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
